// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, redirect flush, fixed-latency multi-cycle EX stall.
// Optional perf counters (StallCnt/FlushCnt) are built only when HAZ_PERF_CNT_EN is defined.
//
// state   | meaning
// RUN     | normal flow; redirect, MC start and load-use are resolved here
// MC_BUSY | multi-cycle op held in EX; front end and ID/EX frozen, cnt counts down
// MC_DONE | MC result valid for one cycle; no stall from the MC op itself
module hazard_ctrl #(
  parameter int MC_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        McStartE,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        FlushD,
  output logic        FlushE,
  output logic        StallE,
  output logic        McDoneE,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  localparam int CW = $clog2(MC_LAT);

  typedef enum logic [1:0] {RUN, MC_BUSY, MC_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;

  assign load_use = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PCWrite    = 1'b1;
    IF_IDWrite = 1'b1;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    StallE     = 1'b0;
    McDoneE    = 1'b0;
    // outputs stay idle while reset is held low
    if (reset) begin
      case (state_q)
        RUN: begin
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (McStartE) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            StallE     = 1'b1;
            cnt_d      = CW'(MC_LAT - 2);
            state_d    = MC_BUSY;
          end else if (load_use) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            FlushE     = 1'b1;
          end
        end
        MC_BUSY: begin
          PCWrite    = 1'b0;
          IF_IDWrite = 1'b0;
          StallE     = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else             state_d = MC_DONE;
        end
        MC_DONE: begin
          McDoneE = 1'b1;
          state_d = RUN;
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_use) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            FlushE     = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ~PCWrite};
    flush_cnt_d = flush_cnt_q + {31'd0, FlushD};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule
